// File: rtl/dense_layer_ctrl_pkg.sv
// Shared FSM encoding and width helpers for the dense-layer controller and its neuron datapath.
// Pure declarations: no latency, no backpressure.
package dense_layer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_START   = 3'd3,
        ST_RUN     = 3'd4,
        ST_EMIT    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // Full-precision dot-product result width, shared with the neuron.
    function automatic int res_w(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_layer_ctrl_if.sv
// Scheduler, weight-memory and neuron signals of the dense-layer controller.
// Wires only: no latency, no backpressure.
interface dense_layer_ctrl_if
    import dense_layer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 2,
    parameter int AW    = 2
);
    localparam int VW = WIDTH * SIZE;
    localparam int RW = res_w(WIDTH);

    logic                 start;
    logic [VW-1:0]        in_vec;
    logic                 busy;
    logic                 layer_done;
    logic                 err;

    logic                 w_rd_en;
    logic [AW-1:0]        w_addr;
    logic [VW-1:0]        w_rdata;

    logic                 n_reset;
    logic                 n_start;
    logic [VW-1:0]        n_weights;
    logic [VW-1:0]        n_inputs;
    logic signed [RW-1:0] n_result;
    logic                 n_valid;
    logic                 n_done;

    logic                 out_valid;
    logic [AW-1:0]        out_idx;
    logic signed [RW-1:0] out_data;

    modport master (
        input  start, in_vec, w_rdata, n_result, n_valid, n_done,
        output busy, layer_done, err, w_rd_en, w_addr, n_reset, n_start,
               n_weights, n_inputs, out_valid, out_idx, out_data
    );

    modport slave (
        output start, in_vec, w_rdata, n_result, n_valid, n_done,
        input  busy, layer_done, err, w_rd_en, w_addr, n_reset, n_start,
               n_weights, n_inputs, out_valid, out_idx, out_data
    );

endinterface

// File: rtl/dense_layer_ctrl_watchdog.sv
// RUN-state watchdog: expire_o rises on the cycle the count would reach TIMEOUT-1.
// Combinational expire from registered count; no backpressure.
module dense_layer_ctrl_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 2));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dense_layer_ctrl.sv
// Time-shares one neuron across NUM_NEURONS rows: fetch weights, run, ReLU, emit (idx, value).
// Row latency 4 + neuron RUN cycles; start is dropped while busy, no output backpressure.
module dense_layer_ctrl
    import dense_layer_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SIZE        = 2,
    parameter int NUM_NEURONS = 4,
    parameter int AW          = addr_w(NUM_NEURONS),
    parameter int RELU        = 0,
    parameter int TIMEOUT     = 64
) (
    input logic              clk,
    input logic              reset,
    dense_layer_ctrl_if.master bus
);
    localparam int VW = WIDTH * SIZE;
    localparam int RW = res_w(WIDTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 err_q, err_d;
    logic [VW-1:0]        vec_q;
    logic [VW-1:0]        wgt_q;
    logic [AW-1:0]        oidx_q;
    logic signed [RW-1:0] odat_q;
    logic signed [RW-1:0] relu_res;

    logic busy, layer_done, w_rd_en, n_reset, n_start, out_valid;
    logic wd_clr, wd_en, wd_exp;

    dense_layer_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .rst      (reset),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_exp)
    );

    // Sign-bit clamp only; the result width is passed through unchanged.
    assign relu_res = ((RELU != 0) && bus.n_result[RW-1]) ? '0 : bus.n_result;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        busy       = 1'b1;
        layer_done = 1'b0;
        w_rd_en    = 1'b0;
        n_reset    = 1'b0;
        n_start    = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy    = 1'b0;
                n_reset = 1'b1;
                if (bus.start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_rd_en = 1'b1;
                n_reset = 1'b1;
                state_d = ST_WAIT_RD;
            end
            ST_WAIT_RD: state_d = ST_START;
            ST_START: begin
                n_start = 1'b1;
                wd_clr  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wd_en = 1'b1;
                if (bus.n_done) begin
                    if (bus.n_valid) begin
                        state_d = ST_EMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (wd_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                layer_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            vec_q   <= '0;
            wgt_q   <= '0;
            oidx_q  <= '0;
            odat_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (state_q == ST_IDLE && bus.start) begin
                vec_q <= bus.in_vec;
            end
            if (state_q == ST_WAIT_RD) begin
                wgt_q <= bus.w_rdata;
            end
            // Output registers change only on entry to EMIT, so they hold between rows.
            if (state_q == ST_RUN && bus.n_done && bus.n_valid) begin
                oidx_q <= idx_q;
                odat_q <= relu_res;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.layer_done = layer_done;
    assign bus.err        = err_q;
    assign bus.w_rd_en    = w_rd_en;
    assign bus.w_addr     = idx_q;
    assign bus.n_reset    = n_reset;
    assign bus.n_start    = n_start;
    assign bus.n_weights  = wgt_q;
    assign bus.n_inputs   = vec_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_idx    = oidx_q;
    assign bus.out_data   = odat_q;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Two controllers (RELU=0 and RELU=1) run in lockstep on one ROM and one neuron model.
// Expected rows come from plain integer dot products of the ROM rows and the start vector.
`timescale 1ns/1ps
module tb_dense_layer_ctrl;
    import dense_layer_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int SIZE  = 2;
    localparam int NN    = 3;
    localparam int AW    = 2;
    localparam int TO    = 8;
    localparam int VW    = WIDTH * SIZE;
    localparam int RW    = 2 * WIDTH + 1;

    typedef struct { int idx; int data; } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [VW-1:0] in_vec = '0;
    logic [VW-1:0] w_rdata = '0;
    logic signed [RW-1:0] n_result = '0;
    logic n_valid = 1'b0;
    logic n_done = 1'b0;

    always #5 clk = ~clk;

    dense_layer_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE), .AW(AW)) if0 ();
    dense_layer_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE), .AW(AW)) if1 ();

    assign if0.start = start;    assign if1.start = start;
    assign if0.in_vec = in_vec;  assign if1.in_vec = in_vec;
    assign if0.w_rdata = w_rdata; assign if1.w_rdata = w_rdata;
    assign if0.n_result = n_result; assign if1.n_result = n_result;
    assign if0.n_valid = n_valid; assign if1.n_valid = n_valid;
    assign if0.n_done = n_done;  assign if1.n_done = n_done;

    dense_layer_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_NEURONS(NN), .AW(AW),
                       .RELU(0), .TIMEOUT(TO)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    dense_layer_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_NEURONS(NN), .AW(AW),
                       .RELU(1), .TIMEOUT(TO)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    logic [VW-1:0] rom [4];
    int nmode = 0;   // 0 normal, 1 never done, 2 done without valid
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, ld_cnt = 0, ld_cyc = 0, ns_cyc = 0;
    logic err_at_ld = 1'b0;
    ev_t q0[$], q1[$];
    int lb = 0, qb0 = 0, qb1 = 0;

    function automatic int elem(input logic [VW-1:0] x, input int i);
        logic signed [WIDTH-1:0] e;
        e = x[i*WIDTH +: WIDTH];
        return int'(e);
    endfunction

    function automatic int exp_val(input int r, input logic [VW-1:0] v, input bit relu);
        int s;
        s = 0;
        for (int i = 0; i < SIZE; i++) s += elem(rom[r], i) * elem(v, i);
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    function automatic logic [VW-1:0] pack2(input int a, input int b);
        logic [7:0] la, lb8;
        la = a[7:0];
        lb8 = b[7:0];
        return {lb8, la};
    endfunction

    // 1-cycle-latency weight ROM.
    always @(posedge clk) if (if0.w_rd_en) w_rdata <= rom[if0.w_addr];

    // Neuron: result ready 2..5 cycles after n_start, from the operands the DUT presents.
    logic pend = 1'b0;
    int rem = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0; n_done <= 1'b0; n_valid <= 1'b0; n_result <= '0;
        end else begin
            n_done <= 1'b0;
            n_valid <= 1'b0;
            if (if0.n_reset) begin
                pend <= 1'b0;
            end else if (if0.n_start) begin
                pend <= 1'b1;
                rem <= int'($urandom_range(3, 0));
                n_result <= RW'(elem(if0.n_weights, 0) * elem(if0.n_inputs, 0)
                              + elem(if0.n_weights, 1) * elem(if0.n_inputs, 1));
            end else if (pend && nmode != 1) begin
                if (rem == 0) begin
                    pend <= 1'b0;
                    n_done <= 1'b1;
                    n_valid <= (nmode == 0);
                end else begin
                    rem <= rem - 1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (if0.out_valid) q0.push_back('{idx: int'(if0.out_idx), data: int'(if0.out_data)});
            if (if1.out_valid) q1.push_back('{idx: int'(if1.out_idx), data: int'(if1.out_data)});
            if (if0.n_start) ns_cyc <= cyc;
            if (if0.layer_done) begin
                ld_cnt <= ld_cnt + 1;
                ld_cyc <= cyc;
                err_at_ld <= if0.err;
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [VW-1:0] v);
        lb = ld_cnt; qb0 = q0.size(); qb1 = q1.size();
        start = 1'b1; in_vec = v;
        @(posedge clk); #1;
        start = 1'b0; in_vec = ~v;
    endtask

    task automatic wait_ld(input string tag);
        int b;
        b = 0;
        while (ld_cnt == lb && b < 300) begin @(posedge clk); #1; b++; end
        chk({tag, "_done_in_time"}, (ld_cnt != lb), 1);
    endtask

    task automatic wait_row1_run(input string tag);
        int b;
        b = 0;
        while (q0.size() == qb0 && b < 100) begin @(posedge clk); #1; b++; end
        while (!if0.n_start && b < 200) begin @(posedge clk); #1; b++; end
        chk({tag, "_reached_row1"}, (b < 200), 1);
        @(posedge clk); #1;
    endtask

    task automatic finish_layer(input string tag, input logic [VW-1:0] v, input int rows, input logic eerr);
        wait_ld(tag);
        repeat (2) @(posedge clk); #1;
        chk({tag, "_layer_done_once"}, ld_cnt - lb, 1);
        chk({tag, "_err"}, err_at_ld, eerr);
        chk({tag, "_busy_after"}, if0.busy, 0);
        chk({tag, "_rows_relu0"}, q0.size() - qb0, rows);
        chk({tag, "_rows_relu1"}, q1.size() - qb1, rows);
        for (int i = 0; i < rows && qb0 + i < q0.size() && qb1 + i < q1.size(); i++) begin
            chk($sformatf("%s_idx%0d", tag, i), q0[qb0+i].idx, i);
            chk($sformatf("%s_data%0d", tag, i), q0[qb0+i].data, exp_val(i, v, 0));
            chk($sformatf("%s_relu%0d", tag, i), q1[qb1+i].data, exp_val(i, v, 1));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, if0.busy, 0);
        chk({tag, "_n_reset"}, if0.n_reset, 1);
        chk({tag, "_layer_done"}, if0.layer_done, 0);
        chk({tag, "_err"}, if0.err, 0);
        chk({tag, "_w_rd_en"}, if0.w_rd_en, 0);
        chk({tag, "_n_start"}, if0.n_start, 0);
        chk({tag, "_out_valid"}, if0.out_valid, 0);
        chk({tag, "_out_data"}, if0.out_data, 0);
        chk({tag, "_out_idx"}, if0.out_idx, 0);
        chk({tag, "_n_weights"}, if0.n_weights, 0);
        chk({tag, "_n_inputs"}, if0.n_inputs, 0);
        chk({tag, "_busy_relu1"}, if1.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [VW-1:0] v, v2;
        int k;

        rom[0] = pack2(4, 3); rom[1] = pack2(-2, -1); rom[2] = pack2(2, 3); rom[3] = '0;
        #1;
        chk_reset_outputs("reset");
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Directed layer: RELU=0 gives 14,-6,10; RELU=1 clamps row 1.
        v = pack2(2, 2);
        do_start(v);
        chk("accept_busy", if0.busy, 1);
        k = 0;
        while (!if0.out_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("first_out_latency_ge5", (k + 1 >= 5), 1);
        finish_layer("dir", v, NN, 1'b0);

        // Random layers.
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < NN; r++) rom[r] = VW'($urandom);
            v = VW'($urandom);
            do_start(v);
            finish_layer($sformatf("rnd%0d", t), v, NN, 1'b0);
        end

        // start re-pulsed during RUN of row 1 is ignored.
        v = VW'($urandom);
        v2 = v ^ 16'h5a5a;
        do_start(v);
        wait_row1_run("repulse");
        start = 1'b1; in_vec = v2;
        @(posedge clk); #1;
        start = 1'b0;
        finish_layer("repulse", v, NN, 1'b0);
        chk("repulse_n_inputs_kept", if0.n_inputs, v);
        repeat (10) @(posedge clk); #1;
        chk("repulse_no_second_layer", ld_cnt - lb, 1);

        // Neuron never completes: watchdog abort 8 cycles after n_start.
        nmode = 1;
        do_start(v);
        finish_layer("timeout", v, 0, 1'b1);
        chk("timeout_latency", ld_cyc - ns_cyc, 8);
        chk("timeout_err_sticky", if0.err, 1);
        nmode = 0;
        do_start(v);
        chk("err_cleared_on_start", if0.err, 0);
        finish_layer("after_timeout", v, NN, 1'b0);

        // Done without valid on row 0.
        nmode = 2;
        do_start(v);
        finish_layer("novalid", v, 0, 1'b1);
        nmode = 0;

        // Asynchronous reset in the middle of row 1.
        v = VW'($urandom);
        do_start(v);
        wait_row1_run("midreset");
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1; reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("midreset_no_layer_done", ld_cnt - lb, 0);
        chk("midreset_rows_before", q0.size() - qb0, 1);
        v = VW'($urandom);
        do_start(v);
        finish_layer("post_reset", v, NN, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
